fadd_issue: RTL and testbench

Issue/retire pipeline stage wrapped around the combinational single-precision adder `fadd`. It accepts tagged add/subtract requests over a valid/ready handshake and registers operands into stage 1, which drives the adder's `x1`/`x2`. It captures the adder's `y`/`ovf` into stage 2 and presents the tagged result downstream over a second valid/ready handshake. It also keeps a sticky overflow flag for the FPU status register.

---
 rtl/fadd_issue.sv | 127 ++++++++++++
 tb/tb_fadd_issue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue.sv
// Two-stage issue/retire wrapper around the combinational single-precision adder.
// Optional FADD_ISSUE_SKID_EN adds a one-entry skid buffer so in_ready has no out_ready path.
module fadd_issue #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      add_x1,
  output logic [31:0]      add_x2,
  input  logic [31:0]      add_y,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_free;
  logic             s1_move;
  logic             accept;
  logic [31:0]      in_x2;

  logic             s1_load;
  logic [31:0]      load_x1;
  logic [31:0]      load_x2;
  logic [TAG_W-1:0] load_tag;

  // Subtraction is folded into operand B by flipping its sign bit, whatever it encodes.
  assign in_x2   = in_op ? {~in_b[31], in_b[30:0]} : in_b;
  assign s2_free = ~out_valid | out_ready;
  assign s1_move = s1_valid & s2_free;

`ifdef FADD_ISSUE_SKID_EN
  logic             skid_valid;
  logic [31:0]      skid_x1;
  logic [31:0]      skid_x2;
  logic [TAG_W-1:0] skid_tag;
  logic             s1_open;

  assign s1_open  = ~s1_valid | s2_free;
  assign in_ready = ~rst & ~skid_valid;
  assign accept   = in_valid & in_ready;

  // The skid entry is older than anything on the input, so it has priority into S1.
  always_comb begin
    s1_load  = s1_open & (skid_valid | accept);
    load_x1  = skid_valid ? skid_x1  : in_a;
    load_x2  = skid_valid ? skid_x2  : in_x2;
    load_tag = skid_valid ? skid_tag : in_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_x1    <= '0;
      skid_x2    <= '0;
      skid_tag   <= '0;
    end else if (skid_valid) begin
      if (s1_open) skid_valid <= 1'b0;
    end else if (accept & ~s1_open) begin
      skid_valid <= 1'b1;
      skid_x1    <= in_a;
      skid_x2    <= in_x2;
      skid_tag   <= in_tag;
    end
  end
`else
  assign in_ready = ~rst & (~s1_valid | s2_free);
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_load  = accept;
    load_x1  = in_a;
    load_x2  = in_x2;
    load_tag = in_tag;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      add_x1   <= '0;
      add_x2   <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      add_x1   <= load_x1;
      add_x2   <= load_x2;
      s1_tag   <= load_tag;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_ovf    <= 1'b0;
      out_tag    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (s1_move) begin
        out_valid <= 1'b1;
        out_y     <= add_y;
        out_ovf   <= add_ovf;
        out_tag   <= s1_tag;
      end else if (s2_free) begin
        out_valid <= 1'b0;
      end
      // A new overflow in the same cycle as a clear keeps the flag set.
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | (s1_move & add_ovf);
    end
  end

endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue; the adder is a lookup of hand-computed sums.
// Build with FADD_ISSUE_SKID_EN defined to exercise the skid-buffer variant.
module tb_fadd_issue;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      add_x1;
  logic [31:0]      add_x2;
  logic [31:0]      add_y;
  logic             add_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;
  logic             ovf_sticky;
  logic             ovf_clr;

  int pass_cnt = 0;
  int total_cnt = 0;

  fadd_issue #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .add_x1(add_x1), .add_x2(add_x2), .add_y(add_y), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_ovf(out_ovf), .out_tag(out_tag),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational adder stand-in: exact sums for every operand pair this bench issues.
  always_comb begin
    add_ovf = 1'b0;
    case ({add_x1, add_x2})
      {32'h3F800000, 32'h40000000}: add_y = 32'h40400000;
      {32'h40400000, 32'hBF800000}: add_y = 32'h40000000;
      {32'h7F7FFFFF, 32'h7F7FFFFF}: begin add_y = 32'h7F800000; add_ovf = 1'b1; end
      {32'h3F800000, 32'hBF800000}: add_y = 32'h00000000;
      {32'h3F800000, 32'h3F800000}: add_y = 32'h40000000;
      {32'h40000000, 32'h3F800000}: add_y = 32'h40400000;
      {32'h40400000, 32'h3F800000}: add_y = 32'h40800000;
      {32'h40800000, 32'h3F800000}: add_y = 32'h40A00000;
      {32'h40A00000, 32'h3F800000}: add_y = 32'h40C00000;
      {32'h40C00000, 32'h3F800000}: add_y = 32'h40E00000;
      default: add_y = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic             op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_x2;
    logic [31:0]      exp_y;
    logic             exp_ovf;
    logic             exp_sticky;
  } vec_t;

  vec_t vecs[4];
  logic [31:0] s_a[6];
  logic [31:0] s_y[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, stalls, edge_changes, seen_valid;
    logic ir_after;

    vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 5'd3, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h40400000, 32'h3F800000, 5'd4, 32'hBF800000, 32'h40000000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd5, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h3F800000, 32'h3F800000, 5'd6, 32'hBF800000, 32'h00000000, 1'b0, 1'b1};
    s_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    s_y = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; ovf_clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_add_x1", add_x1, 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single transactions from the vector table
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_tag = vecs[i].tag;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_add_x1", i), add_x1, vecs[i].a);
      chk($sformatf("v%0d_add_x2", i), add_x2, vecs[i].exp_x2);
      chk($sformatf("v%0d_early_valid", i), {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_out_y", i), out_y, vecs[i].exp_y);
      chk($sformatf("v%0d_out_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
      chk($sformatf("v%0d_out_ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_sticky", i), {31'd0, ovf_sticky}, {31'd0, vecs[i].exp_sticky});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_drain", i), {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Overflow retiring in the same cycle as a clear: set wins, then clear takes effect
    ovf_clr = 1'b1;
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h7F7FFFFF; in_b = 32'h7F7FFFFF; in_tag = 5'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("clr_set_wins", {31'd0, ovf_sticky}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("clr_clears", {31'd0, ovf_sticky}, 32'd0);
    ovf_clr = 1'b0;
    @(posedge clk); #1;

    // Six back-to-back adds with out_ready low for cycles 2..5
    sent = 0; rcv = 0; stalls = 0; edge_changes = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      in_valid = (sent < 6);
      in_op = 1'b0;
      in_a = (sent < 6) ? s_a[sent] : 32'd0;
      in_b = 32'h3F800000;
      in_tag = TAG_W'(sent);
      out_ready = !(cyc >= 2 && cyc <= 5);
      #1 ir_after = in_ready;
      @(negedge clk);
      if (in_ready !== ir_after) edge_changes++;
      if (in_valid && !in_ready) stalls++;
      if (out_valid && out_ready) begin
        chk($sformatf("s%0d_tag", rcv), {27'd0, out_tag}, rcv);
        chk($sformatf("s%0d_y", rcv), out_y, s_y[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_count", rcv, 32'd6);
    chk("stream_stalled", {31'd0, stalls > 0}, 32'd1);
`ifdef FADD_ISSUE_SKID_EN
    chk("skid_ready_edge_only", edge_changes, 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h7F7FFFFF; in_b = 32'h7F7FFFFF; in_tag = 5'd7;
    @(posedge clk); #1;
    in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_sticky", {31'd0, ovf_sticky}, 32'd1);
    chk("full_add_x1", add_x1, 32'h3F800000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_add_x1", add_x1, 32'd0);
    chk("mid_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    seen_valid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("after_rst_no_output", seen_valid, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
